nibble_serial_subtractor: RTL and testbench



---
 rtl/nibble_serial_subtractor_pkg.sv | 17 +
 rtl/nibble_serial_subtractor_cla.sv | 34 +++
 rtl/nibble_serial_subtractor.sv | 148 ++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared state encoding, nibble width and overflow helper for the nibble-serial subtractor.
package sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow of a - b from the sign bits of a, b and the result.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_cla.sv
// Combinational 4-bit carry-lookahead subtract stage: s = x + ~y + cin.
module cla_nibble_sub
  import sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] w_yn;
  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W:0]   w_c;

  assign w_yn = ~y;
  assign w_g  = x & w_yn;
  assign w_p  = x ^ w_yn;

  // Fully expanded lookahead: every carry depends only on g, p and cin.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[NIBBLE_W-1:0];
  assign cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial unsigned subtractor (a - b), LSB nibble first, start/valid handshake.
// Define SIGNED_OVERFLOW_EN to add the two's-complement overflow output ovf.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SIGNED_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  generate
    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
      $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_valid;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
`ifdef SIGNED_OVERFLOW_EN
  logic               r_ovf;
`endif

  logic [NIBBLE_W-1:0] w_s;
  logic                w_cout;
  logic                w_accept;
  logic                w_last;
  logic [WIDTH-1:0]    w_acc_next;

  cla_nibble_sub u_cla (
    .x    (r_a[NIBBLE_W-1:0]),
    .y    (r_b[NIBBLE_W-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  assign w_accept   = (r_state == IDLE) & start;
  assign w_last     = (r_state == RUN) & (r_cnt == CNT_LAST);
  // New nibble enters at the top; after NIB steps the LSB nibble has reached bit 0.
  assign w_acc_next = WIDTH'({w_s, r_acc} >> NIBBLE_W);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand shift registers, nibble counter, running difference and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_carry  <= 1'b1;
      r_cnt    <= {CNT_W{1'b0}};
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_diff   <= {WIDTH{1'b0}};
      r_borrow <= 1'b0;
`ifdef SIGNED_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_ready <= (w_state_next == IDLE);
      r_valid <= w_last;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= 1'b1;
        r_cnt   <= {CNT_W{1'b0}};
      end else if (r_state == RUN) begin
        r_a     <= r_a >> NIBBLE_W;
        r_b     <= r_b >> NIBBLE_W;
        r_acc   <= w_acc_next;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
        // Results are published only on the final step so they hold across new operations.
        if (w_last) begin
          r_diff   <= w_acc_next;
          r_borrow <= ~w_cout;
`ifdef SIGNED_OVERFLOW_EN
          r_ovf    <= ovf_calc(r_a[NIBBLE_W-1], r_b[NIBBLE_W-1], w_s[NIBBLE_W-1]);
`endif
        end
      end
    end
  end

  assign ready  = r_ready;
  assign valid  = r_valid;
  assign diff   = r_diff;
  assign borrow = r_borrow;
`ifdef SIGNED_OVERFLOW_EN
  assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench: directed vectors on a 16-bit instance, then a random sweep on WIDTH 4/8/32.
`timescale 1ns/1ps
module tb_nibble_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        m_start;
  logic [15:0] m_a, m_b, m_diff;
  logic        m_ready, m_valid, m_borrow;
`ifdef SIGNED_OVERFLOW_EN
  logic        m_ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;
  bit       sweep_go   = 1'b0;
  bit [2:0] sweep_done = 3'b000;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  nibble_serial_subtractor #(.WIDTH(16)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (m_start),
    .a      (m_a),
    .b      (m_b),
    .ready  (m_ready),
    .valid  (m_valid),
    .diff   (m_diff),
    .borrow (m_borrow)
`ifdef SIGNED_OVERFLOW_EN
    ,
    .ovf    (m_ovf)
`endif
  );

  // Monitor for the 16-bit instance: pop the scoreboard on every valid pulse.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (m_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(m_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("diff", 64'(m_diff), 64'(e.d));
        chk("borrow", 64'(m_borrow), 64'(e.bo));
`ifdef SIGNED_OVERFLOW_EN
        chk("ovf", 64'(m_ovf), 64'(e.ov));
`endif
      end
    end
  end

  // Issue one operation, push its hand-computed result and wait for valid.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] ed,
                       input logic ebo, input logic eov, input bit chk_lat);
    int n, lat, rlow;
    n = 0;
    @(negedge clk);
    while (m_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (m_ready !== 1'b1) chk("idle_ready_timeout", 64'(m_ready), 64'd1);
    m_a = ta;
    m_b = tb;
    m_start = 1'b1;
    exp_q.push_back('{d: ed, bo: ebo, ov: eov});
    @(negedge clk);
    m_start = 1'b0;
    lat  = 1;
    rlow = (m_ready === 1'b0) ? 1 : 0;
    while (m_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (m_ready === 1'b0) rlow++;
    end
    if (chk_lat) begin
      chk("latency", 64'(lat), 64'd5);
      chk("ready_low_cycles", 64'(rlow), 64'd5);
    end else if (m_valid !== 1'b1) begin
      chk("valid_timeout", 64'(m_valid), 64'd1);
    end
  endtask

  initial begin : main
    int n;
    m_start = 1'b0;
    m_a = 16'h0000;
    m_b = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 64'(m_ready), 64'd1);
    chk("reset_valid", 64'(m_valid), 64'd0);
    chk("reset_diff", 64'(m_diff), 64'd0);
    chk("reset_borrow", 64'(m_borrow), 64'd0);

    issue(16'h1234, 16'h0FFF, 16'h0235, 1'b0, 1'b0, 1'b1);
    issue(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    issue(16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b0);

    // start held high with operands changing every cycle: accepts only every 6th cycle
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      case (i)
        0: begin m_a = 16'h3000; m_b = 16'h1001; end
        6: begin m_a = 16'h0100; m_b = 16'h0200; end
        12: begin m_a = 16'h7FFF; m_b = 16'h8000; end
        default: begin m_a = 16'hDEAD; m_b = 16'(16'h0BAD + i); end
      endcase
      m_start = 1'b1;
      if (i == 0) exp_q.push_back('{d: 16'h1FFF, bo: 1'b0, ov: 1'b0});
      if (i == 6) exp_q.push_back('{d: 16'hFF00, bo: 1'b1, ov: 1'b0});
      if (i == 12) exp_q.push_back('{d: 16'hFFFF, bo: 1'b1, ov: 1'b1});
      chk($sformatf("stream_ready_%0d", i), 64'(m_ready), ((i % 6) == 0) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    m_start = 1'b0;
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // Abort in the second RUN cycle: no result expected
    m_a = 16'hFFFF;
    m_b = 16'h0001;
    m_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 64'(m_ready), 64'd1);
    chk("abort_valid", 64'(m_valid), 64'd0);
    chk("abort_diff", 64'(m_diff), 64'd0);
    chk("abort_borrow", 64'(m_borrow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_abort_ready", 64'(m_ready), 64'd1);
    issue(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);

    sweep_go = 1'b1;
    n = 0;
    while (sweep_done != 3'b111 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (sweep_done != 3'b111) chk("sweep_timeout", 64'(sweep_done), 64'd7);
    chk("main_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Random sweep over several widths against the reference a - b model.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 8 : 32);
    logic         s_start, s_ready, s_valid, s_borrow;
    logic [W-1:0] s_a, s_b, s_diff;
`ifdef SIGNED_OVERFLOW_EN
    logic         s_ovf;
`endif
    logic [W+1:0] s_q[$];

    nibble_serial_subtractor #(.WIDTH(W)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (s_start),
      .a      (s_a),
      .b      (s_b),
      .ready  (s_ready),
      .valid  (s_valid),
      .diff   (s_diff),
      .borrow (s_borrow)
`ifdef SIGNED_OVERFLOW_EN
      ,
      .ovf    (s_ovf)
`endif
    );

    initial begin : drv
      logic [W-1:0] d;
      int n;
      s_start = 1'b0;
      s_a = {W{1'b0}};
      s_b = {W{1'b0}};
      wait (sweep_go);
      for (int i = 0; i < 1000; i++) begin
        n = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 40) begin
          @(negedge clk);
          n++;
        end
        if (s_ready !== 1'b1) begin
          chk($sformatf("w%0d_ready_timeout", W), 64'(s_ready), 64'd1);
          break;
        end
        s_a = W'($urandom);
        s_b = W'($urandom);
        if (i == 0) s_b = s_a;
        if (i == 1) begin
          s_a = {W{1'b0}};
          s_b = W'(1);
        end
        d = s_a - s_b;
        s_start = 1'b1;
        s_q.push_back({(s_a[W-1] ^ s_b[W-1]) & (d[W-1] ^ s_a[W-1]), (s_a < s_b), d});
        @(negedge clk);
        s_start = 1'b0;
      end
      n = 0;
      while (s_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("w%0d_drained", W), 64'(s_q.size()), 64'd0);
      sweep_done[g] = 1'b1;
    end

    always @(negedge clk) begin : mon
      logic [W+1:0] e;
      if (s_valid === 1'b1) begin
        if (s_q.size() == 0) begin
          chk($sformatf("w%0d_unexpected_valid", W), 64'(s_valid), 64'd0);
        end else begin
          e = s_q.pop_front();
          chk($sformatf("w%0d_diff", W), 64'(s_diff), 64'(e[W-1:0]));
          chk($sformatf("w%0d_borrow", W), 64'(s_borrow), 64'(e[W]));
`ifdef SIGNED_OVERFLOW_EN
          chk($sformatf("w%0d_ovf", W), 64'(s_ovf), 64'(e[W+1]));
`endif
        end
      end
    end
  end

endmodule
